// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: 3-bit operation encodings and helpers.
package counter_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_UP1  = 3'b000;
    localparam mode_t MODE_DN1  = 3'b001;
    localparam mode_t MODE_DNS  = 3'b010;
    localparam mode_t MODE_UPS  = 3'b011;
    localparam mode_t MODE_LOAD = 3'b100;
    localparam mode_t MODE_HOLD = 3'b101;
    localparam mode_t MODE_CLR  = 3'b110;

    // Unit-step modes move by one; the other count modes move by the STEP parameter.
    function automatic logic isUnitStep(mode_t m);
        return (m == MODE_UP1) || (m == MODE_DN1);
    endfunction

endpackage

// File: rtl/counter_step_alu.sv
// Combinational next-count logic: modulo/saturating step arithmetic and load range check.
module counter_step_alu
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int STEP     = 3,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nextQ,
    output logic             wrap,
    output logic             loadStb,
    output logic             loadErr
);

    // One extra bit so q+STEP and MODULUS itself (up to 2**WIDTH) are representable.
    localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] TOP_W  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);
    localparam bit             SAT    = (SATURATE != 0);

    logic [WIDTH:0] qExt;
    logic [WIDTH:0] dExt;
    logic [WIDTH:0] stepAmt;
    logic [WIDTH:0] upSum;
    logic [WIDTH:0] upNext;
    logic [WIDTH:0] dnNext;
    logic [WIDTH:0] nextExt;
    logic           upWrap;
    logic           dnWrap;
    logic           dOver;
    logic           unusedMsb;

    always_comb begin
        qExt    = {1'b0, q};
        dExt    = {1'b0, d};
        stepAmt = isUnitStep(mode) ? ONE_W : STEP_W;
        upSum   = qExt + stepAmt;
        upWrap  = (upSum >= MOD_W);
        dnWrap  = (qExt < stepAmt);
        dOver   = (dExt >= MOD_W);

        if (upWrap) begin
            upNext = SAT ? TOP_W : (upSum - MOD_W);
        end else begin
            upNext = upSum;
        end

        // Adding (MODULUS - step) keeps the borrow case non-negative at WIDTH+1 bits.
        if (dnWrap) begin
            dnNext = SAT ? '0 : (qExt + (MOD_W - stepAmt));
        end else begin
            dnNext = qExt - stepAmt;
        end
    end

    always_comb begin
        nextExt = qExt;
        wrap    = 1'b0;
        loadStb = 1'b0;
        loadErr = 1'b0;
        case (mode)
            MODE_UP1, MODE_UPS: begin
                nextExt = upNext;
                wrap    = upWrap;
            end
            MODE_DN1, MODE_DNS: begin
                nextExt = dnNext;
                wrap    = dnWrap;
            end
            MODE_LOAD: begin
                nextExt = dOver ? TOP_W : dExt;
                loadStb = 1'b1;
                loadErr = dOver;
            end
            MODE_HOLD: begin
                nextExt = qExt;
            end
            MODE_CLR: begin
                nextExt = '0;
            end
            default: begin
                nextExt = '0;
            end
        endcase
    end

    // Every legal next value is below MODULUS <= 2**WIDTH, so the top bit is always zero.
    assign nextQ     = nextExt[WIDTH-1:0];
    assign unusedMsb = nextExt[WIDTH];

endmodule

// File: rtl/counter_mod_step.sv
// Parametrised up/down/step/load counter with registered carry, load and load-error strobes.
module counter_mod_step
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int STEP     = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             load,
    output logic             load_err
);

    if (WIDTH < 1 || WIDTH > 30) begin : gBadWidth
        $fatal(1, "counter_mod_step: WIDTH must be 1..30");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : gBadModulus
        $fatal(1, "counter_mod_step: MODULUS must be 2..2**WIDTH");
    end
    if (STEP < 1 || STEP >= MODULUS) begin : gBadStep
        $fatal(1, "counter_mod_step: STEP must be 1..MODULUS-1");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             rco_q;
    logic             rco_d;
    logic             load_q;
    logic             load_d;
    logic             loadErr_q;
    logic             loadErr_d;

    logic [WIDTH-1:0] aluNext;
    logic             aluWrap;
    logic             aluLoad;
    logic             aluErr;

    counter_step_alu #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) uAlu (
        .q       (count_q),
        .mode    (mode),
        .d       (d),
        .nextQ   (aluNext),
        .wrap    (aluWrap),
        .loadStb (aluLoad),
        .loadErr (aluErr)
    );

    // Enable gates the whole operation; when low the count holds and every strobe drops.
    always_comb begin
        count_d   = count_q;
        rco_d     = 1'b0;
        load_d    = 1'b0;
        loadErr_d = 1'b0;
        if (enable) begin
            count_d   = aluNext;
            rco_d     = aluWrap;
            load_d    = aluLoad;
            loadErr_d = aluErr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            rco_q     <= 1'b0;
            load_q    <= 1'b0;
            loadErr_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            rco_q     <= rco_d;
            load_q    <= load_d;
            loadErr_q <= loadErr_d;
        end
    end

    assign q        = count_q;
    assign rco      = rco_q;
    assign load     = load_q;
    assign load_err = loadErr_q;

endmodule
